// File: rtl/zion_basic_circuit_lib_hs_reg_slice.sv
// Two-entry valid/ready register slice (skid buffer).
// Forward (data/valid) and backward (ready) paths are both registered.
module zion_basic_circuit_lib_hs_reg_slice #(
  parameter int                 WIDTH    = 8,
  parameter logic [WIDTH-1:0]   INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iClr,
  input  logic             iVld,
  output logic             oRdy,
  input  logic [WIDTH-1:0] iDat,
  output logic             oVld,
  input  logic             iRdy,
  output logic [WIDTH-1:0] oDat,
  output logic [1:0]       oCnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  if (WIDTH < 1) begin : g_width_chk
`ifdef CHECK_ERR_EXIT
    $fatal(1, "zion_basic_circuit_lib_hs_reg_slice: WIDTH must be >= 1");
`else
    $error("zion_basic_circuit_lib_hs_reg_slice: WIDTH must be >= 1");
`endif
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             acc, pop;

  assign oVld = (state_q != EMPTY);
  assign oRdy = (state_q != FULL);
  assign oDat = main_q;
  assign acc  = iVld & oRdy;
  assign pop  = oVld & iRdy;

  // State encoding equals occupancy, so the count is the state itself.
  assign oCnt = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (iClr) begin
      state_d = EMPTY;
      main_d  = INI_DATA;
      skid_d  = INI_DATA;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_d  = iDat;
            state_d = ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_d = iDat;
          end else if (acc) begin
            skid_d  = iDat;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= INI_DATA;
      skid_q  <= INI_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_zion_basic_circuit_lib_hs_reg_slice.sv
// Self-checking bench for the two-entry register slice: occupancy model,
// in-order scoreboard, vector table and directed corner sequences.
module tb_zion_basic_circuit_lib_hs_reg_slice;

  localparam int         W   = 8;
  localparam logic [7:0] INI = 8'h3C;

  logic         clk, rst, iClr, iVld, iRdy, oVld, oRdy;
  logic [W-1:0] iDat, oDat;
  logic [1:0]   oCnt;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];

  zion_basic_circuit_lib_hs_reg_slice #(.WIDTH(W), .INI_DATA(INI)) dut (
    .clk(clk), .rst(rst), .iClr(iClr), .iVld(iVld), .oRdy(oRdy), .iDat(iDat),
    .oVld(oVld), .iRdy(iRdy), .oDat(oDat), .oCnt(oCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic       rdy;
    logic [7:0] dat;
    logic [1:0] exp_cnt;
    logic       exp_vld;
    logic       exp_rdy;
    logic [7:0] exp_dat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check outputs against the model, account handshakes, advance.
  task automatic cycle();
    logic acc, pop;
    acc = iVld & oRdy;
    pop = oVld & iRdy;
    chk("cnt", 32'(oCnt), 32'(q.size()));
    chk("ovld", 32'(oVld), 32'(q.size() != 0));
    chk("ordy", 32'(oRdy), 32'(q.size() != 2));
    if (pop && q.size() != 0) begin
      chk("data", 32'(oDat), 32'(q[0]));
      void'(q.pop_front());
    end
    if (iClr) q.delete();
    else if (acc) q.push_back(iDat);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [1:0] c, input logic v,
                         input logic r, input logic [7:0] d);
    chk({name, "_cnt"}, 32'(oCnt), 32'(c));
    chk({name, "_vld"}, 32'(oVld), 32'(v));
    chk({name, "_rdy"}, 32'(oRdy), 32'(r));
    chk({name, "_dat"}, 32'(oDat), 32'(d));
  endtask

  vec_t vt[6];
  int   sent;
  int   budget;

  initial begin
    vt[0] = '{1'b1, 1'b0, 8'hA1, 2'd1, 1'b1, 1'b1, 8'hA1};
    vt[1] = '{1'b1, 1'b0, 8'hA2, 2'd2, 1'b1, 1'b0, 8'hA1};
    vt[2] = '{1'b1, 1'b0, 8'hA3, 2'd2, 1'b1, 1'b0, 8'hA1};
    vt[3] = '{1'b1, 1'b1, 8'hA3, 2'd1, 1'b1, 1'b1, 8'hA2};
    vt[4] = '{1'b1, 1'b1, 8'hA3, 2'd1, 1'b1, 1'b1, 8'hA3};
    vt[5] = '{1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 1'b1, 8'hA3};

    rst = 1'b0; iClr = 1'b0; iVld = 1'b0; iRdy = 1'b0; iDat = '0;
    // Reset then idle: asynchronous pulse mid-cycle.
    #3 rst = 1'b1;
    #1 chk_out("rst", 2'd0, 1'b0, 1'b1, INI);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk_out("idle", 2'd0, 1'b0, 1'b1, INI);
    end

    // Streaming at full rate.
    iRdy = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      iVld = 1'b1; iDat = 8'(k);
      cycle();
      chk_out("stream", 2'd1, 1'b1, 1'b1, 8'(k));
    end
    iVld = 1'b0;
    cycle();
    chk_out("stream_drain", 2'd0, 1'b0, 1'b1, 8'd16);

    // Skid fill vector table.
    for (int i = 0; i < 6; i++) begin
      iVld = vt[i].vld; iRdy = vt[i].rdy; iDat = vt[i].dat;
      cycle();
      chk_out($sformatf("skid%0d", i), vt[i].exp_cnt, vt[i].exp_vld, vt[i].exp_rdy, vt[i].exp_dat);
    end

    // Random backpressure against the scoreboard.
    sent = 0;
    budget = 0;
    while (sent < 1000 && budget < 20000) begin
      iVld = 1'($urandom_range(0, 1));
      iRdy = 1'($urandom_range(0, 3) != 0);
      iDat = 8'($urandom);
      if (iVld && oRdy) sent++;
      cycle();
      budget++;
    end
    chk("rand_sent", 32'(sent), 32'd1000);
    iVld = 1'b0; iRdy = 1'b1;
    budget = 0;
    while (q.size() != 0 && budget < 10) begin
      cycle();
      budget++;
    end
    chk("rand_drained", 32'(q.size()), 32'd0);

    // Flush while FULL with a beat presented in the same cycle.
    iRdy = 1'b0; iVld = 1'b1; iDat = 8'h11; cycle();
    iDat = 8'h22; cycle();
    chk_out("pre_flush", 2'd2, 1'b1, 1'b0, 8'h11);
    iClr = 1'b1; iDat = 8'h33; cycle();
    iClr = 1'b0; iVld = 1'b0;
    chk_out("flush", 2'd0, 1'b0, 1'b1, INI);
    iRdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_out("post_flush", 2'd0, 1'b0, 1'b1, INI);
    end

    // Reset while FULL, then first beat after release.
    iRdy = 1'b0; iVld = 1'b1; iDat = 8'h44; cycle();
    iDat = 8'h55; cycle();
    chk_out("pre_rst", 2'd2, 1'b1, 1'b0, 8'h44);
    iVld = 1'b0;
    #2 rst = 1'b1;
    #1 chk_out("mid_rst", 2'd0, 1'b0, 1'b1, INI);
    q.delete();
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    iVld = 1'b1; iDat = 8'h5A; cycle();
    iVld = 1'b0;
    chk_out("after_rst", 2'd1, 1'b1, 1'b1, 8'h5A);
    iRdy = 1'b1; cycle();
    chk_out("final", 2'd0, 1'b0, 1'b1, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
